// File: rtl/otter_intr_ctrl.sv
// MMIO interrupt controller: edge-latched pending flags, enable mask and fixed-priority dispatch
// of one INTR pulse per source, held in service until software writes its index to CLEAR.
module otter_intr_ctrl #(
   parameter int          NUM_SRC     = 4,
   parameter logic [31:0] BASE_AD     = 32'h1124_0000,
   parameter int          INTR_CYCLES = 2
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [NUM_SRC-1:0] IRQ_IN,
   input  logic [31:0]        IOBUS_ADDR,
   input  logic [31:0]        IOBUS_OUT,
   input  logic               IOBUS_WR,
   output logic [31:0]        IOBUS_RD,
   output logic               HIT,
   output logic               INTR,
   output logic [1:0]         fsm_state
);
   localparam int CW = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(INTR_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSERT   = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_SRC-1:0] irq_q;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr_vec;
   logic [2:0]         svc_id;
   logic [2:0]         win_id;
   logic [2:0]         clr_id;
   logic [CW-1:0]      cnt;
   logic               word_ok;
   logic               wr_mask;
   logic               wr_clear;
   logic               clr_valid;
   logic               clr_svc;
   logic               in_service;
   logic               unused_bits;

   // Only whole-word accesses inside the 16-byte window map to a register.
   assign HIT         = (IOBUS_ADDR[31:4] == BASE_AD[31:4]);
   assign word_ok     = HIT && (IOBUS_ADDR[1:0] == 2'b00);
   assign wr_mask     = IOBUS_WR && word_ok && (IOBUS_ADDR[3:2] == 2'd1);
   assign wr_clear    = IOBUS_WR && word_ok && (IOBUS_ADDR[3:2] == 2'd3);
   assign clr_id      = IOBUS_OUT[2:0];
   assign clr_valid   = wr_clear && (32'(clr_id) < NUM_SRC);
   assign clr_svc     = clr_valid && (clr_id == svc_id);
   assign rise        = IRQ_IN & ~irq_q;
   assign eligible    = pending & mask;
   assign in_service  = (state != IDLE);
   assign fsm_state   = state;
   assign unused_bits = ^IOBUS_OUT;

   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (clr_valid && (clr_id == 3'(i))) clr_vec[i] = 1'b1;
      end
   end

   // Scan downwards so the lowest eligible index is the one left in win_id.
   always_comb begin
      win_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) win_id = 3'(i);
      end
   end

   always_comb begin
      IOBUS_RD = '0;
      if (word_ok) begin
         case (IOBUS_ADDR[3:2])
            2'd0:    IOBUS_RD[NUM_SRC-1:0] = pending;
            2'd1:    IOBUS_RD[NUM_SRC-1:0] = mask;
            2'd2:    if (in_service) IOBUS_RD = {1'b1, 28'd0, svc_id};
            default: IOBUS_RD = '0;
         endcase
      end
   end

   // A new rising edge is OR-ed in after the clear, so set wins over a same-cycle CLEAR.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         irq_q   <= '0;
         pending <= '0;
         mask    <= '0;
      end else begin
         irq_q   <= IRQ_IN;
         pending <= (pending & ~clr_vec) | rise;
         if (wr_mask) mask <= IOBUS_OUT[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= IDLE;
         svc_id <= '0;
         cnt    <= '0;
         INTR   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|eligible) begin
                  svc_id <= win_id;
                  cnt    <= CNT_LOAD;
                  INTR   <= 1'b1;
                  state  <= ASSERT;
               end
            end
            ASSERT: begin
               if (clr_svc || (cnt == '0)) begin
                  INTR  <= 1'b0;
                  state <= clr_svc ? IDLE : WAIT_ACK;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            WAIT_ACK: begin
               if (clr_svc) state <= IDLE;
            end
            default: begin
               INTR  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: directed scenarios plus a randomized run, all checked against a
// behavioural model of pending flags, mask and the in-service source.
module tb_otter_intr_ctrl;
   localparam int          NUM_SRC     = 4;
   localparam logic [31:0] BASE_AD     = 32'h1124_0000;
   localparam int          INTR_CYCLES = 2;
   localparam logic [31:0] A_PEND      = BASE_AD + 32'h0;
   localparam logic [31:0] A_MASK      = BASE_AD + 32'h4;
   localparam logic [31:0] A_ID        = BASE_AD + 32'h8;
   localparam logic [31:0] A_CLR       = BASE_AD + 32'hC;

   logic               CLK = 1'b0;
   logic               RESET_N;
   logic [NUM_SRC-1:0] IRQ_IN;
   logic [31:0]        IOBUS_ADDR;
   logic [31:0]        IOBUS_OUT;
   logic               IOBUS_WR;
   logic [31:0]        IOBUS_RD;
   logic               HIT;
   logic               INTR;
   logic [1:0]         fsm_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   otter_intr_ctrl #(
      .NUM_SRC(NUM_SRC), .BASE_AD(BASE_AD), .INTR_CYCLES(INTR_CYCLES)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IRQ_IN(IRQ_IN), .IOBUS_ADDR(IOBUS_ADDR),
      .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR), .IOBUS_RD(IOBUS_RD), .HIT(HIT),
      .INTR(INTR), .fsm_state(fsm_state)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   bit m_prev[NUM_SRC];
   bit m_pend[NUM_SRC];
   bit m_mask[NUM_SRC];
   bit m_busy;
   int m_svc;
   int m_left;

   task automatic model_reset();
      for (int i = 0; i < NUM_SRC; i++) begin
         m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
      end
      m_busy = 0; m_svc = 0; m_left = 0;
   endtask

   task automatic model_step(input logic [NUM_SRC-1:0] irq, input logic wr,
                             input logic [31:0] addr, input logic [31:0] data);
      bit rise[NUM_SRC];
      bit mapped;
      int off;
      int clr;
      int win;
      mapped = wr && (addr[31:4] == BASE_AD[31:4]) && (addr[1:0] == 2'b00);
      off    = int'(addr[3:2]);
      clr    = (mapped && off == 3 && int'(data[2:0]) < NUM_SRC) ? int'(data[2:0]) : -1;
      for (int i = 0; i < NUM_SRC; i++) begin
         rise[i]   = irq[i] && !m_prev[i];
         m_prev[i] = irq[i];
      end
      if (!m_busy) begin
         win = -1;
         for (int i = NUM_SRC - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
         if (win >= 0) begin
            m_busy = 1; m_svc = win; m_left = INTR_CYCLES;
         end
      end else if (clr == m_svc) begin
         m_busy = 0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (clr == i) m_pend[i] = 0;
         if (rise[i]) m_pend[i] = 1;
      end
      if (mapped && off == 1) for (int i = 0; i < NUM_SRC; i++) m_mask[i] = data[i];
   endtask

   function automatic logic [31:0] exp_pending();
      logic [31:0] v = '0;
      for (int i = 0; i < NUM_SRC; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_mask();
      logic [31:0] v = '0;
      for (int i = 0; i < NUM_SRC; i++) v[i] = m_mask[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_id();
      return m_busy ? (32'h8000_0000 | 32'(m_svc)) : 32'h0;
   endfunction

   function automatic logic exp_intr();
      return m_busy && (m_left > 0);
   endfunction

   // ---------------- drivers ----------------
   task automatic tick(input logic [NUM_SRC-1:0] irq, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
      IRQ_IN = irq; IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = data;
      @(posedge CLK);
      model_step(irq, wr, addr, data);
      #1;
      IOBUS_WR = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] d);
      IOBUS_WR = 1'b0; IOBUS_ADDR = addr;
      #1;
      d = IOBUS_RD;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d;
      RESET_N = 1'b0; IRQ_IN = '0; IOBUS_WR = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b exp 0", INTR); end
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h exp 0", d); end
      rd(A_MASK, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h exp 0", d); end
      rd(A_ID, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_id: got %h exp 0", d); end
      IRQ_IN = 4'b0100;
      #2 RESET_N = 1'b1;
      #1;
      tick(4'b0100, 1'b0, 32'h0, 32'h0);
      rd(A_PEND, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL release_edge_pending: got %h exp 4", d); end
      tick(4'b0100, 1'b1, A_CLR, 32'h2);
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL release_clear: got %h exp 0", d); end
      tick(4'b0000, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_basic_dispatch();
      logic [31:0] d;
      int high;
      bit fell;
      tick(4'b0000, 1'b1, A_MASK, 32'h2);
      tick(4'b0010, 1'b0, 32'h0, 32'h0);
      rd(A_PEND, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_pending: got %h exp 2", d); end
      high = 0; fell = 0;
      for (int c = 0; c < 10 && !fell; c++) begin
         tick(4'b0000, 1'b0, 32'h0, 32'h0);
         checks++;
         if (INTR !== exp_intr()) begin errors++; $display("FAIL basic_intr c%0d: got %b exp %b", c, INTR, exp_intr()); end
         if (INTR === 1'b1) high++;
         else if (high > 0) fell = 1;
      end
      checks++; if (high != INTR_CYCLES) begin errors++; $display("FAIL basic_intr_width: got %0d exp %0d", high, INTR_CYCLES); end
      rd(A_ID, d);
      checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL basic_id: got %h exp 80000001", d); end
      tick(4'b0000, 1'b1, A_CLR, 32'h1);
      rd(A_ID, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_id_clear: got %h exp 0", d); end
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_clear: got %h exp 0", d); end
   endtask

   task automatic test_priority_back_to_back();
      logic [31:0] d;
      logic [31:0] e;
      logic prev;
      bit do_clr;
      logic [31:0] clr_val;
      int rise_t[$];
      exp_q = {32'h8000_0000, 32'h8000_0003};
      tick(4'b0000, 1'b1, A_MASK, 32'hF);
      tick(4'b1001, 1'b0, 32'h0, 32'h0);
      prev = 1'b0; do_clr = 0; clr_val = '0;
      for (int c = 0; c < 30; c++) begin
         if (do_clr) tick(4'b0000, 1'b1, A_CLR, clr_val);
         else        tick(4'b0000, 1'b0, 32'h0, 32'h0);
         do_clr = 0;
         checks++;
         if (INTR !== exp_intr()) begin errors++; $display("FAIL prio_intr c%0d: got %b exp %b", c, INTR, exp_intr()); end
         if (INTR === 1'b1 && prev !== 1'b1) rise_t.push_back(c);
         if (INTR !== 1'b1 && prev === 1'b1 && exp_q.size() > 0) begin
            rd(A_ID, d);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin errors++; $display("FAIL prio_order: got %h exp %h", d, e); end
            do_clr = 1; clr_val = {29'd0, e[2:0]};
         end
         prev = INTR;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prio_served: got %0d left exp 0", exp_q.size()); end
      checks++;
      if (rise_t.size() != 2) begin
         errors++; $display("FAIL prio_pulses: got %0d exp 2", rise_t.size());
      end else if (rise_t[1] - rise_t[0] != INTR_CYCLES + 2) begin
         errors++; $display("FAIL prio_gap: got %0d exp %0d", rise_t[1] - rise_t[0], INTR_CYCLES + 2);
      end
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL prio_pend_end: got %h exp 0", d); end
   endtask

   task automatic test_masked_latch();
      logic [31:0] d;
      bit seen;
      bit fell;
      tick(4'b0000, 1'b1, A_MASK, 32'h0);
      tick(4'b0100, 1'b0, 32'h0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick(4'b0000, 1'b0, 32'h0, 32'h0);
         checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL masked_intr c%0d: got %b exp 0", c, INTR); end
      end
      rd(A_PEND, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL masked_pending: got %h exp 4", d); end
      tick(4'b0000, 1'b1, A_MASK, 32'h4);
      seen = 0;
      for (int c = 0; c < 2 && !seen; c++) begin
         if (INTR === 1'b1) seen = 1;
         else tick(4'b0000, 1'b0, 32'h0, 32'h0);
      end
      if (INTR === 1'b1) seen = 1;
      checks++; if (!seen) begin errors++; $display("FAIL unmask_intr: got 0 exp 1 within 2 clks"); end
      fell = 0;
      for (int c = 0; c < 8 && !fell; c++) begin
         tick(4'b0000, 1'b0, 32'h0, 32'h0);
         if (INTR === 1'b0) fell = 1;
      end
      rd(A_ID, d);
      checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL unmask_id: got %h exp 80000002", d); end
      tick(4'b0000, 1'b1, A_CLR, 32'h2);
      rd(A_ID, d);
      checks++; if (d !== exp_id()) begin errors++; $display("FAIL unmask_id_clear: got %h exp %h", d, exp_id()); end
   endtask

   task automatic test_set_wins();
      logic [31:0] d;
      bit fell;
      tick(4'b0000, 1'b1, A_MASK, 32'h2);
      tick(4'b0010, 1'b0, 32'h0, 32'h0);
      fell = 0;
      for (int c = 0; c < 8 && !fell; c++) begin
         tick(4'b0000, 1'b0, 32'h0, 32'h0);
         if (INTR === 1'b0 && exp_id() != 0) fell = 1;
      end
      checks++; if (!fell) begin errors++; $display("FAIL setwins_wait: got no WAIT_ACK exp one"); end
      tick(4'b0010, 1'b1, A_CLR, 32'h1);
      rd(A_PEND, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL setwins_pending: got %h exp 2", d); end
      rd(A_ID, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL setwins_idle: got %h exp 0", d); end
      tick(4'b0010, 1'b0, 32'h0, 32'h0);
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL setwins_redispatch: got %b exp 1", INTR); end
      rd(A_ID, d);
      checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL setwins_id: got %h exp 80000001", d); end
      tick(4'b0010, 1'b1, A_CLR, 32'h1);
      rd(A_PEND, d);
      checks++; if (d !== exp_pending()) begin errors++; $display("FAIL setwins_end: got %h exp %h", d, exp_pending()); end
      tick(4'b0000, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset_mid_assert();
      logic [31:0] d;
      tick(4'b0000, 1'b1, A_MASK, 32'h1);
      tick(4'b0001, 1'b0, 32'h0, 32'h0);
      tick(4'b0001, 1'b0, 32'h0, 32'h0);
      checks++; if (INTR !== 1'b1) begin errors++; $display("FAIL mid_assert_pre: got %b exp 1", INTR); end
      RESET_N = 1'b0;
      model_reset();
      #1;
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL mid_reset_intr: got %b exp 0", INTR); end
      rd(A_PEND, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_pend: got %h exp 0", d); end
      rd(A_MASK, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_mask: got %h exp 0", d); end
      rd(A_ID, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_id: got %h exp 0", d); end
      RESET_N = 1'b1;
      tick(4'b0001, 1'b0, 32'h0, 32'h0);
      tick(4'b0001, 1'b1, A_CLR, 32'h7);
      tick(4'b0001, 1'b1, A_PEND, 32'hF);
      tick(4'b0001, 1'b1, BASE_AD + 32'h14, 32'hFF);
      tick(4'b0001, 1'b1, A_ID, 32'h8000_0003);
      rd(A_PEND, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL ignore_pend: got %h exp 1", d); end
      rd(A_MASK, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL ignore_mask: got %h exp 0", d); end
      rd(A_ID, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL ignore_id: got %h exp 0", d); end
      checks++; if (INTR !== 1'b0) begin errors++; $display("FAIL ignore_intr: got %b exp 0", INTR); end
      tick(4'b0000, 1'b1, A_CLR, 32'h0);
   endtask

   task automatic test_readback();
      logic [31:0] d;
      rd(A_CLR, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_clear: got %h exp 0", d); end
      rd(BASE_AD + 32'h10, d);
      checks++; if (d !== 32'h0 || HIT !== 1'b0) begin errors++; $display("FAIL rd_miss: got %h hit %b exp 0 hit 0", d, HIT); end
      rd(A_ID, d);
      checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL hit_in_block: got %b exp 1", HIT); end
      tick(4'b0000, 1'b1, A_MASK, 32'hFFFF_FFF5);
      rd(A_MASK, d);
      checks++; if (d !== 32'h5) begin errors++; $display("FAIL rd_mask: got %h exp 5", d); end
      tick(4'b0000, 1'b1, A_MASK, 32'h0);
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [NUM_SRC-1:0] irq;
      int r;
      for (int c = 0; c < 400; c++) begin
         irq = NUM_SRC'($urandom_range(0, (1 << NUM_SRC) - 1));
         r = $urandom_range(0, 9);
         if (r < 3)       tick(irq, 1'b1, A_CLR, ($urandom & ~32'h7) | 32'($urandom_range(0, NUM_SRC)));
         else if (r == 3) tick(irq, 1'b1, A_MASK, $urandom);
         else if (r == 4) tick(irq, 1'b1, BASE_AD + 32'($urandom_range(0, 15)), $urandom);
         else             tick(irq, 1'b0, 32'h0, 32'h0);
         checks++;
         if (INTR !== exp_intr()) begin errors++; $display("FAIL rand_intr c%0d: got %b exp %b", c, INTR, exp_intr()); end
         rd(A_PEND, d);
         checks++;
         if (d !== exp_pending()) begin errors++; $display("FAIL rand_pend c%0d: got %h exp %h", c, d, exp_pending()); end
         rd(A_ID, d);
         checks++;
         if (d !== exp_id()) begin errors++; $display("FAIL rand_id c%0d: got %h exp %h", c, d, exp_id()); end
         rd(A_MASK, d);
         checks++;
         if (d !== exp_mask()) begin errors++; $display("FAIL rand_mask c%0d: got %h exp %h", c, d, exp_mask()); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_dispatch();
      test_priority_back_to_back();
      test_masked_latch();
      test_set_wins();
      test_reset_mid_assert();
      test_readback();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit, exp finish before it");
      $fatal(1, "watchdog");
   end
endmodule
